divider_rr_stg: RTL and testbench
=================================

DIVIDER_RR_STG -- requirements
Module: divider_rr_stg

Interface
REQ-001 Parameter L_divn, default 8, dividend and quotient width.
REQ-002 Parameter L_divr, default 4, divisor and remainder width.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 word1  input  L_divn  unsigned dividend; sampled only on accepted Start.
REQ-006 word2  input  L_divr  unsigned divisor; sampled only on accepted Start.
REQ-007 Start  input  1  request a division; level-sampled while idle.
REQ-008 quotient  output  L_divn  unsigned quotient word1/word2.
REQ-009 remainder  output  L_divr  unsigned remainder word1%word2.
REQ-010 Ready  output  1  high when idle; results valid while high.
REQ-011 Error  output  1  high while in the divide-by-zero error state.
REQ-012 Port order: quotient, remainder, Ready, Error, word1, word2, Start, clock, reset.

Function
REQ-013 Three states SHALL exist: S_idle, S_div, S_err.
REQ-014 S_idle: Ready=1, Error=0, quotient/remainder hold the last result.
REQ-015 S_idle, Start=1, word2!=0 -> load dividend register <= word1, remainder register <= 0, iteration counter <= 0; go to S_div.
REQ-016 S_idle, Start=1, word2==0 -> go to S_err; no registers besides state change.
REQ-017 S_div: Ready=0, Error=0; one restoring iteration per clock.
REQ-018 Iteration: shift {remainder, dividend} left 1 bit; comparison (L_divr+1 bits) = shifted upper part minus divisor; if comparison non-negative, upper part <= comparison[L_divr-1:0] and dividend[0] <= 1, else restore (keep shifted value) and dividend[0] <= 0.
REQ-019 The dividend register SHALL double as the quotient register (reduced-register form); quotient output = dividend register, remainder output = remainder register.
REQ-020 After exactly L_divn iterations, return to S_idle; Ready rises on the clock edge completing iteration L_divn (latency L_divn+1 clocks from the accepting Start edge to Ready=1).
REQ-021 Start is ignored during S_div and S_err; word1/word2 changes during S_div do not affect the result.
REQ-022 Start held high on return to S_idle SHALL start a new division on the next edge.
REQ-023 S_err: Ready=0, Error=1; remain until reset (sticky).
REQ-024 word1=0 SHALL yield quotient 0, remainder 0 in L_divn+1 clocks; word2=1 yields quotient=word1, remainder 0.

Reset
REQ-025 reset=1 at a clock edge: state <= S_idle, dividend/quotient <= 0, remainder <= 0, counter <= 0, Error=0, Ready=1 from that edge.
REQ-026 reset has priority over Start in every state, including mid-division and S_err; an interrupted division is discarded.
REQ-027 Start and reset both high: reset wins; Start is evaluated on the first edge after reset deasserts.

Structure
REQ-028 A shared package SHALL hold the state encoding (S_idle, S_div, S_err) and default widths L_divn=8, L_divr=4.
REQ-029 Counter width SHALL be clog2(L_divn+1) bits.
REQ-030 One sub-module is natural: divider_rr_stg_datapath (shift/subtract/restore step), controlled by the FSM in the top module.

Verification
REQ-031 Reset then Start with word2=0 -> Error=1, Ready=0 next clock; holds until reset; reset -> Error=0, Ready=1.
REQ-032 word1=255, word2=15, Start pulse -> Ready low 8 clocks, then quotient=17, remainder=0.
REQ-033 word1=100, word2=7 -> quotient=14, remainder=2; word1=1, word2=15 -> quotient=0, remainder=1.
REQ-034 Exhaustive: word1 1..255, word2 1..15, one Start per pair, wait for Ready -> quotient/remainder match integer divide/modulo for all 3825 pairs.
REQ-035 Assert reset mid-division (4th iteration) -> Ready=1, quotient=0, remainder=0 next clock; subsequent 200/9 -> 22 rem 2.
REQ-036 Change word1/word2 during S_div -> result reflects values sampled at Start.

Source files
------------

// File: rtl/divider_rr_stg_pkg.sv
// Shared definitions for the restoring divider: default widths and FSM state encoding.
package divider_rr_stg_pkg;

  localparam int L_DIVN_DEFAULT = 8;
  localparam int L_DIVR_DEFAULT = 4;

  typedef enum logic [1:0] {
    S_idle = 2'd0,
    S_div  = 2'd1,
    S_err  = 2'd2
  } state_t;

endpackage

// File: rtl/divider_rr_stg_datapath.sv
// One restoring shift/subtract step per enabled clock. The dividend register
// fills with quotient bits from the LSB as the dividend bits shift out the top.
module divider_rr_stg_datapath
  import divider_rr_stg_pkg::*;
#(
  parameter int L_divn = L_DIVN_DEFAULT,
  parameter int L_divr = L_DIVR_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [L_divn-1:0] i_dividend,
  input  logic [L_divr-1:0] i_divisor,
  output logic [L_divn-1:0] o_quotient,
  output logic [L_divr-1:0] o_remainder
);

  logic [L_divn-1:0] r_div;
  logic [L_divr-1:0] r_rem;
  logic [L_divr-1:0] r_dvs;

  logic [L_divr:0]   w_shift_hi;
  logic [L_divr+1:0] w_diff;
  logic              w_fits;

  // Shifted partial remainder can reach 2*divisor-1, so it needs one extra bit;
  // the subtraction gets a further sign bit to tell fit from restore.
  assign w_shift_hi = {r_rem, r_div[L_divn-1]};
  assign w_diff     = {1'b0, w_shift_hi} - {2'b00, r_dvs};
  assign w_fits     = ~w_diff[L_divr+1];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_div <= '0;
      r_rem <= '0;
      r_dvs <= '0;
    end else if (i_load) begin
      r_div <= i_dividend;
      r_rem <= '0;
      r_dvs <= i_divisor;
    end else if (i_step) begin
      r_rem <= w_fits ? w_diff[L_divr-1:0] : w_shift_hi[L_divr-1:0];
      r_div <= {r_div[L_divn-2:0], w_fits};
    end
  end

  assign o_quotient  = r_div;
  assign o_remainder = r_rem;

endmodule

// File: rtl/divider_rr_stg.sv
// Sequential restoring divider: idle/divide/error FSM driving a one-step datapath.
// Divide-by-zero parks in a sticky error state until reset.
module divider_rr_stg
  import divider_rr_stg_pkg::*;
#(
  parameter int L_divn = L_DIVN_DEFAULT,
  parameter int L_divr = L_DIVR_DEFAULT
) (
  output logic [L_divn-1:0] quotient,
  output logic [L_divr-1:0] remainder,
  output logic              Ready,
  output logic              Error,
  input  logic [L_divn-1:0] word1,
  input  logic [L_divr-1:0] word2,
  input  logic              Start,
  input  logic              clock,
  input  logic              reset
);

  localparam int CNT_W = $clog2(L_divn + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(L_divn - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_load;
  logic             w_step;
  logic             w_zero_div;

  assign w_zero_div = (word2 == '0);

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_idle;
    else       r_state <= w_next;
  end

  always_ff @(posedge clock) begin
    if (reset)       r_cnt <= '0;
    else if (w_load) r_cnt <= '0;
    else if (w_step) r_cnt <= r_cnt + CNT_W'(1);
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_idle:  if (Start) w_next = w_zero_div ? S_err : S_div;
      S_div:   if (r_cnt == LAST_ITER) w_next = S_idle;
      S_err:   w_next = S_err;
      default: w_next = S_idle;
    endcase
  end

  always_comb begin
    Ready  = 1'b0;
    Error  = 1'b0;
    w_load = 1'b0;
    w_step = 1'b0;
    case (r_state)
      S_idle: begin
        Ready  = 1'b1;
        w_load = Start && !w_zero_div;
      end
      S_div:   w_step = 1'b1;
      S_err:   Error  = 1'b1;
      default: ;
    endcase
  end

  divider_rr_stg_datapath #(
    .L_divn(L_divn),
    .L_divr(L_divr)
  ) u_datapath (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_dividend (word1),
    .i_divisor  (word2),
    .o_quotient (quotient),
    .o_remainder(remainder)
  );

endmodule

// File: tb/tb_divider_rr_stg.sv
// Scenario-driven bench for divider_rr_stg; expected results come from integer
// divide/modulo pushed to a queue at Start and popped when Ready returns.
module tb_divider_rr_stg;

  localparam int L_divn = 8;
  localparam int L_divr = 4;

  logic [L_divn-1:0] quotient;
  logic [L_divr-1:0] remainder;
  logic              Ready;
  logic              Error;
  logic [L_divn-1:0] word1;
  logic [L_divr-1:0] word2;
  logic              Start;
  logic              clock;
  logic              reset;

  typedef struct {
    int            a;
    int            b;
    logic [L_divn-1:0] q;
    logic [L_divr-1:0] r;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_err;

  divider_rr_stg #(
    .L_divn(L_divn),
    .L_divr(L_divr)
  ) dut (
    .quotient (quotient),
    .remainder(remainder),
    .Ready    (Ready),
    .Error    (Error),
    .word1    (word1),
    .word2    (word2),
    .Start    (Start),
    .clock    (clock),
    .reset    (reset)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_div(input int a, input int b);
    exp_t e;
    e.a = a;
    e.b = b;
    e.q = L_divn'(a / b);
    e.r = L_divr'(a % b);
    sb.push_back(e);
    word1 = L_divn'(a);
    word2 = L_divr'(b);
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  // Waits for Ready, then checks latency and the popped expected result.
  task automatic wait_result(input string name, input int exp_lows);
    int   lows;
    exp_t e;
    lows = 0;
    while (!Ready && lows < 40) begin
      tick();
      lows++;
    end
    e = sb.pop_front();
    n_cmp++;
    if (lows !== exp_lows) begin
      n_err++;
      $display("FAIL %s latency %0d/%0d: got %0d busy clocks, want %0d",
               name, e.a, e.b, lows, exp_lows);
    end
    n_cmp++;
    if ({quotient, remainder} !== {e.q, e.r}) begin
      n_err++;
      $display("FAIL %s %0d/%0d: got q=%0d r=%0d, want q=%0d r=%0d",
               name, e.a, e.b, quotient, remainder, e.q, e.r);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Start = 1'b0;
    word1 = '0;
    word2 = '0;
    tick();
    tick();
    n_cmp++;
    if ({Ready, Error, quotient, remainder} !== {1'b1, 1'b0, 8'd0, 4'd0}) begin
      n_err++;
      $display("FAIL reset_state: got Ready=%b Error=%b q=%0d r=%0d, want 1 0 0 0",
               Ready, Error, quotient, remainder);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_div_zero();
    word1 = 8'd50;
    word2 = 4'd0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    n_cmp++;
    if ({Ready, Error} !== 2'b01) begin
      n_err++;
      $display("FAIL div_zero_enter: got Ready=%b Error=%b, want 0 1", Ready, Error);
    end
    word2 = 4'd3;
    for (int i = 0; i < 6; i++) begin
      Start = i[0];
      tick();
    end
    Start = 1'b0;
    n_cmp++;
    if ({Ready, Error} !== 2'b01) begin
      n_err++;
      $display("FAIL div_zero_sticky: got Ready=%b Error=%b, want 0 1", Ready, Error);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({Ready, Error} !== 2'b10) begin
      n_err++;
      $display("FAIL div_zero_clear: got Ready=%b Error=%b, want 1 0", Ready, Error);
    end
  endtask

  task automatic test_known_vectors();
    start_div(255, 15); wait_result("known", 8);
    start_div(100, 7);  wait_result("known", 8);
    start_div(1, 15);   wait_result("known", 8);
    start_div(0, 5);    wait_result("known", 8);
    start_div(173, 1);  wait_result("known", 8);
    start_div(254, 2);  wait_result("known", 8);
  endtask

  task automatic test_input_change();
    start_div(200, 9);
    word1 = 8'd3;
    word2 = 4'd0;
    Start = 1'b1;
    tick();
    tick();
    Start = 1'b0;
    word1 = 8'd255;
    word2 = 4'd1;
    n_cmp++;
    if ({Ready, Error} !== 2'b00) begin
      n_err++;
      $display("FAIL start_ignored_busy: got Ready=%b Error=%b, want 0 0", Ready, Error);
    end
    wait_result("input_change", 6);
  endtask

  task automatic test_mid_reset();
    start_div(255, 15);
    tick();
    tick();
    tick();
    reset = 1'b1;
    Start = 1'b1;
    word1 = 8'd200;
    word2 = 4'd9;
    tick();
    void'(sb.pop_back());
    n_cmp++;
    if ({Ready, Error, quotient, remainder} !== {1'b1, 1'b0, 8'd0, 4'd0}) begin
      n_err++;
      $display("FAIL mid_reset: got Ready=%b Error=%b q=%0d r=%0d, want 1 0 0 0",
               Ready, Error, quotient, remainder);
    end
    tick();
    n_cmp++;
    if (Ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_over_start: got Ready=%b, want 1", Ready);
    end
    reset = 1'b0;
    start_div(200, 9);
    wait_result("after_reset", 8);
  endtask

  task automatic test_back_to_back();
    start_div(200, 9);
    Start = 1'b1;
    word1 = 8'd77;
    word2 = 4'd5;
    wait_result("b2b_first", 8);
    start_div(77, 5);
    n_cmp++;
    if (Ready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_restart: got Ready=%b, want 0", Ready);
    end
    wait_result("b2b_second", 8);
  endtask

  task automatic test_exhaustive();
    for (int a = 1; a <= 255; a++) begin
      for (int b = 1; b <= 15; b++) begin
        start_div(a, b);
        wait_result("exhaustive", 8);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_div_zero();
    test_known_vectors();
    test_input_change();
    test_mid_reset();
    test_back_to_back();
    test_exhaustive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
